// File: rtl/seqburst_arbiter_if.sv
// Handshake bundle between the burst arbiter and its two requesters / video memory.
// The slave modport is the arbiter's view; the master modport drives requests and ready.
interface seqburst_arbiter_if #(
    parameter int WWIDTH = 8
);
    logic              req0;
    logic [WWIDTH-1:0] start_addr0;
    logic              req1;
    logic [WWIDTH-1:0] start_addr1;
    logic [1:0]        grant;
    logic [1:0]        done;
    logic [WWIDTH-1:0] addr_out;
    logic              addr_valid;
    logic              addr_ready;
    logic              busy;

    modport slave (
        input  req0, start_addr0, req1, start_addr1, addr_ready,
        output grant, done, addr_out, addr_valid, busy
    );

    modport master (
        output req0, start_addr0, req1, start_addr1, addr_ready,
        input  grant, done, addr_out, addr_valid, busy
    );
endinterface

// File: rtl/seqburst_arbiter.sv
// Round-robin arbiter sharing one burst address sequencer between the display line
// fetch (requester 0) and the auxiliary/CPU fetch (requester 1).
module seqburst_arbiter #(
    parameter int BURSTLEN = 16,
    parameter int STRIDE   = 1,
    parameter int CWIDTH   = 4,
    parameter int WWIDTH   = 8
) (
    input logic              clk,
    input logic              rst,
    seqburst_arbiter_if.slave bus
);
    localparam logic [CWIDTH-1:0] LAST_COUNT = CWIDTH'(BURSTLEN - 1);
    localparam logic [WWIDTH-1:0] STEP       = WWIDTH'(STRIDE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [CWIDTH-1:0] count;
    logic              last;
    logic [1:0]        grant_q;
    logic [1:0]        done_q;
    logic [WWIDTH-1:0] addr_q;
    logic              valid_q;
    logic              busy_q;

    logic              winner;
    logic [WWIDTH-1:0] winner_addr;
    logic              owner;
    logic              owner_req;
    logic              accept;

    // On a tie the requester that was not served last wins; otherwise the lone requester.
    always_comb begin
        winner      = (bus.req0 && bus.req1) ? ~last : bus.req1;
        winner_addr = winner ? bus.start_addr1 : bus.start_addr0;
        owner       = grant_q[1];
        owner_req   = owner ? bus.req1 : bus.req0;
        accept      = valid_q && bus.addr_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            last    <= 1'b1;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 2'b00;
                    if (bus.req0 || bus.req1) begin
                        addr_q  <= winner_addr;
                        grant_q <= winner ? 2'b10 : 2'b01;
                        count   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= BURST;
                    end
                end
                BURST: begin
                    // A dropped request aborts the burst and wins over a completing beat.
                    if (!owner_req) begin
                        grant_q <= 2'b00;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        last    <= owner;
                        state   <= IDLE;
                    end else if (accept) begin
                        if (count == LAST_COUNT) begin
                            valid_q <= 1'b0;
                            done_q  <= grant_q;
                            state   <= DONE;
                        end else begin
                            addr_q <= addr_q + STEP;
                            count  <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 2'b00;
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    last    <= owner;
                    state   <= IDLE;
                end
                default: begin
                    grant_q <= 2'b00;
                    done_q  <= 2'b00;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.addr_out   = addr_q;
    assign bus.addr_valid = valid_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_seqburst_arbiter.sv
// Self-checking bench for seqburst_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level model of arbitration and burst progress.
module tb_seqburst_arbiter;
    localparam int BURSTLEN = 16;
    localparam int STRIDE   = 1;
    localparam int WWIDTH   = 8;

    localparam int PH_IDLE  = 0;
    localparam int PH_BURST = 1;
    localparam int PH_DONE  = 2;

    logic clk;
    logic rst;

    seqburst_arbiter_if #(.WWIDTH(WWIDTH)) bus ();

    seqburst_arbiter #(
        .BURSTLEN(BURSTLEN),
        .STRIDE  (STRIDE),
        .CWIDTH  (4),
        .WWIDTH  (WWIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    int               m_phase;
    int               m_owner;
    int               m_last;
    int               m_beats;
    logic [WWIDTH-1:0] m_start;
    bit               auto_drop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [WWIDTH-1:0] a0,
                                 input logic r1, input logic [WWIDTH-1:0] a1,
                                 input logic rdy);
        bus.req0        = r0;
        bus.start_addr0 = a0;
        bus.req1        = r1;
        bus.start_addr1 = a1;
        bus.addr_ready  = rdy;
    endtask

    task automatic modelReset();
        m_phase = PH_IDLE;
        m_owner = -1;
        m_last  = 1;
        m_beats = 0;
        m_start = '0;
    endtask

    // Advances the model by one clock using the input levels present at the edge.
    task automatic modelEdge();
        logic owner_req;
        case (m_phase)
            PH_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    if (bus.req0 && bus.req1) m_owner = 1 - m_last;
                    else                      m_owner = bus.req1 ? 1 : 0;
                    m_start = (m_owner == 1) ? bus.start_addr1 : bus.start_addr0;
                    m_beats = 0;
                    m_phase = PH_BURST;
                end
            end
            PH_BURST: begin
                owner_req = (m_owner == 1) ? bus.req1 : bus.req0;
                if (!owner_req) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_phase = PH_IDLE;
                end else if (bus.addr_ready) begin
                    m_beats++;
                    if (m_beats == BURSTLEN) m_phase = PH_DONE;
                end
            end
            default: begin
                m_last  = m_owner;
                m_owner = -1;
                m_phase = PH_IDLE;
            end
        endcase
    endtask

    task automatic checkOutput();
        logic [1:0]        exp_grant;
        logic [WWIDTH-1:0] exp_addr;
        exp_grant = (m_owner == 1) ? 2'b10 : (m_owner == 0) ? 2'b01 : 2'b00;
        exp_addr  = m_start + WWIDTH'(m_beats * STRIDE);
        checkOne("grant", 32'(bus.grant), 32'(exp_grant));
        checkOne("done", 32'(bus.done), (m_phase == PH_DONE) ? 32'(exp_grant) : 32'd0);
        checkOne("addr_valid", 32'(bus.addr_valid), 32'(m_phase == PH_BURST));
        checkOne("busy", 32'(bus.busy), 32'(m_phase != PH_IDLE));
        if (m_phase == PH_BURST) checkOne("addr_out", 32'(bus.addr_out), 32'(exp_addr));
    endtask

    // One clock: model follows the edge, outputs are checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
        if (auto_drop && m_phase == PH_DONE) begin
            if (m_owner == 0) bus.req0 = 1'b0;
            else              bus.req1 = 1'b0;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOne({tag, "_grant"}, 32'(bus.grant), 32'd0);
        checkOne({tag, "_done"}, 32'(bus.done), 32'd0);
        checkOne({tag, "_valid"}, 32'(bus.addr_valid), 32'd0);
        checkOne({tag, "_addr"}, 32'(bus.addr_out), 32'd0);
        checkOne({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic resetMid();
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkResetValues("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        checkResetValues("rst_hold");
    endtask

    initial begin
        rst       = 1'b1;
        auto_drop = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;
        tick();

        $display("[TB] single burst from requester 0 at 0x10");
        applyStimulus(1'b1, 8'h10, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 22; i++) tick();

        $display("[TB] both requesters held: alternating bursts");
        resetMid();
        auto_drop = 1'b0;
        applyStimulus(1'b1, 8'h20, 1'b1, 8'hA0, 1'b1);
        for (int i = 0; i < 3 * (BURSTLEN + 2) + 2; i++) tick();
        auto_drop = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        $display("[TB] requester 1 at 0x40 with toggling ready");
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h40, 1'b1);
        for (int i = 0; i < 2 * BURSTLEN + 6; i++) begin
            tick();
            bus.addr_ready = (i % 2 == 1);
        end

        $display("[TB] address wrap from 0xF8");
        applyStimulus(1'b1, 8'hF8, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < BURSTLEN + 4; i++) tick();

        $display("[TB] abort of requester 1 after five beats");
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h80, 1'b1);
        for (int i = 0; i < 40 && !(m_phase == PH_BURST && m_beats == 5); i++) tick();
        checkOne("abort_beats", 32'(m_beats), 32'd5);
        applyStimulus(1'b1, 8'h22, 1'b0, 8'h80, 1'b1);
        tick();
        checkOne("abort_idle_valid", 32'(bus.addr_valid), 32'd0);
        tick();
        checkOne("abort_regrant", 32'(bus.grant), 32'd1);
        for (int i = 0; i < 6; i++) tick();

        $display("[TB] reset in the middle of a burst");
        resetMid();
        applyStimulus(1'b1, 8'h30, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        resetMid();
        applyStimulus(1'b1, 8'h50, 1'b1, 8'h60, 1'b1);
        tick();
        checkOne("post_reset_winner", 32'(bus.grant), 32'd1);
        for (int i = 0; i < BURSTLEN + 3; i++) tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            if (m_phase == PH_IDLE) begin
                bus.req0        = ($urandom_range(0, 1) == 1);
                bus.req1        = ($urandom_range(0, 1) == 1);
                bus.start_addr0 = 8'($urandom);
                bus.start_addr1 = 8'($urandom);
            end else if (m_phase == PH_BURST) begin
                if (m_owner == 0) begin
                    bus.req0 = ($urandom_range(0, 39) != 0);
                    bus.req1 = ($urandom_range(0, 1) == 1);
                end else begin
                    bus.req1 = ($urandom_range(0, 39) != 0);
                    bus.req0 = ($urandom_range(0, 1) == 1);
                end
                bus.start_addr0 = 8'($urandom);
                bus.start_addr1 = 8'($urandom);
            end
            bus.addr_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
